// File: rtl/mul_div_alu_if.sv
// Handshake and operand/result bundle for mul_div_alu.
// The requester (master) presents operations; the ALU (slave) accepts them and returns results.
interface mul_div_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, a, b, flush,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, flush,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mul_div_alu.sv
// Single-issue ALU with HI/LO registers: one-cycle logic/arithmetic/shift ops and
// iterative (one bit per cycle) signed/unsigned multiply and restoring divide.
module mul_div_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic               is_div_reg, is_div_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               dz_reg, dz_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               out_valid_reg, out_valid_next;

    logic               accept;
    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   alu_res;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dshift, ddiff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;

    assign accept    = bus.in_valid && (state_reg == IDLE);
    assign is_signed = ~bus.op[0];
    assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign sh        = bus.a[SHW-1:0];

    // Shift-add step: multiplier sits in the low half and drains out as the product fills in.
    assign msum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    // Restoring step: {remainder, dividend} shifts left one bit, quotient bits enter at the bottom.
    assign dshift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign ddiff  = dshift - {1'b0, opnd_reg};

    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign q_fix    = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign r_fix    = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'd0:  alu_res = bus.a & bus.b;
            4'd1:  alu_res = bus.a | bus.b;
            4'd2:  alu_res = bus.a + bus.b;
            4'd3:  alu_res = bus.a - bus.b;
            4'd4:  alu_res = bus.b << sh;
            4'd5:  alu_res = bus.b >> sh;
            4'd6:  alu_res = $signed(bus.b) >>> sh;
            4'd7:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd12: alu_res = hi_reg;
            4'd13: alu_res = lo_reg;
            4'd14: alu_res = bus.a;
            4'd15: alu_res = bus.a;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        opnd_next      = opnd_reg;
        a_next         = a_reg;
        is_div_next    = is_div_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        dz_next        = dz_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        result_next    = result_reg;
        out_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.op[3:2] == 2'b10) begin
                        state_next  = bus.op[1] ? DIV : MUL;
                        cnt_next    = '0;
                        acc_next    = {{WIDTH{1'b0}}, a_mag};
                        opnd_next   = b_mag;
                        a_next      = bus.a;
                        is_div_next = bus.op[1];
                        neg_q_next  = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r_next  = is_signed && bus.a[WIDTH-1];
                        dz_next     = (bus.b == '0);
                    end else begin
                        out_valid_next = 1'b1;
                        result_next    = alu_res;
                        if (bus.op == 4'd14) hi_next = bus.a;
                        if (bus.op == 4'd15) lo_next = bus.a;
                    end
                end
            end
            MUL: begin
                acc_next = {msum, acc_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = FIN;
            end
            DIV: begin
                if (!ddiff[WIDTH]) acc_next = {ddiff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
                else               acc_next = {dshift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = FIN;
            end
            FIN: begin
                state_next     = IDLE;
                out_valid_next = 1'b1;
                if (!is_div_reg) begin
                    hi_next     = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next     = prod_fix[WIDTH-1:0];
                    result_next = prod_fix[WIDTH-1:0];
                end else if (dz_reg) begin
                    hi_next     = a_reg;
                    lo_next     = '1;
                    result_next = '1;
                end else begin
                    hi_next     = r_fix;
                    lo_next     = q_fix;
                    result_next = q_fix;
                end
            end
            default: state_next = IDLE;
        endcase

        // An abort discards the long operation without touching architectural state.
        if (bus.flush && state_reg != IDLE) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            hi_next        = hi_reg;
            lo_next        = lo_reg;
            result_next    = result_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            opnd_reg      <= '0;
            a_reg         <= '0;
            is_div_reg    <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            opnd_reg      <= opnd_next;
            a_reg         <= a_next;
            is_div_reg    <= is_div_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
            dz_reg        <= dz_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            result_reg    <= result_next;
            out_valid_reg <= out_valid_next;
        end
    end
endmodule

// File: tb/tb_mul_div_alu.sv
// Directed self-checking bench for mul_div_alu at WIDTH=32.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_mul_div_alu;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    mul_div_alu_if #(.WIDTH(32)) bus ();

    mul_div_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Short op: accept on the next edge, result expected right after it.
    task automatic op1(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag, input logic [31:0] exp);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("%s op=%0d a=%h b=%h out_valid=%0b result=%h", tag, o, x, y, bus.out_valid, bus.result);
        chk({tag, "_ov"}, 64'(bus.out_valid), 64'd1);
        chk(tag, 64'(bus.result), 64'(exp));
    endtask

    // Multiply/divide: measure busy cycles and latency, then read HI back.
    task automatic oplong(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        int busy;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        busy = 0;
        while (!bus.out_valid && n < 200) begin
            if (!bus.in_ready) busy++;
            @(posedge clk);
            #1;
            n++;
        end
        $display("%s op=%0d a=%h b=%h edges=%0d busy=%0d result=%h", tag, o, x, y, n, busy, bus.result);
        chk({tag, "_edges"}, 64'(n), 64'd33);
        chk({tag, "_busy"}, 64'(busy), 64'd33);
        chk({tag, "_lo"}, 64'(bus.result), 64'(exp_lo));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
        op1(4'd12, 32'd0, 32'd0, {tag, "_hi"}, exp_hi);
    endtask

    initial begin
        int ov_seen;
        total = 0;
        bad = 0;
        bus.in_valid = 1'b0;
        bus.op = 4'd0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        op1(4'd12, 32'd0, 32'd0, "rst_hi", 32'd0);
        op1(4'd13, 32'd0, 32'd0, "rst_lo", 32'd0);

        // Back-to-back ADD then SRA
        bus.in_valid = 1'b1;
        bus.op = 4'd2;
        bus.a = 32'd5;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        $display("add_b2b out_valid=%0b result=%h", bus.out_valid, bus.result);
        chk("add_b2b_ov", 64'(bus.out_valid), 64'd1);
        chk("add_b2b", 64'(bus.result), 64'd12);
        bus.op = 4'd6;
        bus.a = 32'd4;
        bus.b = 32'h8000_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("sra_b2b out_valid=%0b result=%h", bus.out_valid, bus.result);
        chk("sra_b2b_ov", 64'(bus.out_valid), 64'd1);
        chk("sra_b2b", 64'(bus.result), 64'hF800_0000);
        @(posedge clk);
        #1;
        chk("idle_ov", 64'(bus.out_valid), 64'd0);

        // Single-cycle ops
        op1(4'd7, 32'hFFFF_FFFF, 32'd1, "slt_neg", 32'd1);
        op1(4'd7, 32'd1, 32'hFFFF_FFFF, "slt_pos", 32'd0);
        op1(4'd4, 32'h21, 32'd1, "sll_mask", 32'd2);
        op1(4'd5, 32'd4, 32'h8000_0000, "srl", 32'h0800_0000);
        op1(4'd0, 32'h0000_F0F0, 32'h0000_FF00, "and", 32'h0000_F000);
        op1(4'd1, 32'h0000_F0F0, 32'h0000_FF00, "or", 32'h0000_FFF0);
        op1(4'd2, 32'hFFFF_FFFF, 32'd1, "add_wrap", 32'd0);
        op1(4'd3, 32'd3, 32'd5, "sub_wrap", 32'hFFFF_FFFE);

        // HI/LO moves and preservation across ALU ops
        op1(4'd14, 32'h55, 32'd0, "mthi", 32'h55);
        op1(4'd15, 32'hABCD, 32'd0, "mtlo", 32'hABCD);
        op1(4'd2, 32'd1, 32'd2, "add_mid", 32'd3);
        op1(4'd12, 32'd0, 32'd0, "mfhi_keep", 32'h55);
        op1(4'd13, 32'd0, 32'd0, "mflo_keep", 32'hABCD);

        // Flush in IDLE must not block the accept
        bus.flush = 1'b1;
        op1(4'd2, 32'd10, 32'd20, "flush_idle_add", 32'd30);
        bus.flush = 1'b0;

        // Multiply and divide
        oplong(4'd8, 32'hFFFF_FFFD, 32'd7, "mult", 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        oplong(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu", 32'h0000_0001, 32'hFFFF_FFFE);
        oplong(4'd10, 32'hFFFF_FFF9, 32'd2, "div", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        oplong(4'd11, 32'd7, 32'd0, "divu_z", 32'hFFFF_FFFF, 32'd7);
        oplong(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h8000_0000, 32'd0);
        oplong(4'd11, 32'd100, 32'd7, "divu", 32'd14, 32'd2);

        // Flush mid-DIVU with ADD held on the input
        op1(4'd14, 32'h1234, 32'd0, "mthi_1234", 32'h1234);
        bus.in_valid = 1'b1;
        bus.op = 4'd11;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.op = 4'd2;
        bus.a = 32'd1;
        bus.b = 32'd1;
        ov_seen = 0;
        for (int i = 1; i <= 9; i++) begin
            if (bus.out_valid) ov_seen++;
            @(posedge clk);
            #1;
        end
        if (bus.out_valid) ov_seen++;
        chk("flush_busy_ready", 64'(bus.in_ready), 64'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        $display("flush ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_ov", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) ov_seen++;
            @(posedge clk);
            #1;
        end
        chk("flush_no_ov", 64'(ov_seen), 64'd0);
        op1(4'd12, 32'd0, 32'd0, "flush_mfhi", 32'h1234);

        // Reset five cycles into MULTU
        bus.in_valid = 1'b1;
        bus.op = 4'd9;
        bus.a = 32'd3;
        bus.b = 32'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_ov", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_after_ready", 64'(bus.in_ready), 64'd1);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) ov_seen++;
            @(posedge clk);
            #1;
        end
        $display("reset_abort out_valid_count=%0d", ov_seen);
        chk("rst_no_ov", 64'(ov_seen), 64'd0);
        op1(4'd13, 32'd0, 32'd0, "rst_mflo", 32'd0);
        op1(4'd12, 32'd0, 32'd0, "rst_mfhi", 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
